// File: rtl/lt24_fetch_pkg.sv
// Shared types and constants for the LT24 pixel fetch master.
package lt24_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned PIX_W      = 16;
  localparam int unsigned WORD_W     = 32;
  localparam logic [3:0]  BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/lt24_word_fifo.sv
// Show-ahead word FIFO with synchronous flush; also exposes the entry behind the head.
module lt24_word_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head_c,
  output logic [DATA_W-1:0]            peek_c,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full_c,
  output logic                         empty_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);
  assign head_c  = mem_q[rd_q];
  assign peek_c  = mem_q[rd_q + PW'(1)];
  assign count   = count_q;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    do_push = push && (!full_c || pop);
    do_pop  = pop && !empty_c;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lt24_pixel_fetch_master.sv
// Avalon-MM read master draining a word line from on-chip memory into an RGB565 pixel stream.
module lt24_pixel_fetch_master #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned CNT_W      = 9,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PIX_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last
);

  import lt24_fetch_pkg::state_e;
  import lt24_fetch_pkg::ST_IDLE;
  import lt24_fetch_pkg::ST_FETCH;
  import lt24_fetch_pkg::ST_DRAIN;
  import lt24_fetch_pkg::BYTEEN_ALL;
  import lt24_fetch_pkg::WORD_W;

  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
  localparam int unsigned UW = CW + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, avm_address_q, avm_address_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d, pop_rem_q, pop_rem_d;
  logic              cs_q, cs_d, pend_q, pend_d, half_q, half_d;
  logic              pix_valid_q, pix_valid_d, pix_last_q, pix_last_d;
  logic              done_q, done_d, busy_q, busy_d;
  logic [PIX_W-1:0]  pix_data_q, pix_data_d;

  logic [WORD_W-1:0] fifo_head, fifo_peek;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic              accept_c, credit_ok_c;
  logic [UW-1:0]     used_c;

  lt24_word_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .wdata   (avm_readdata),
    .pop     (fifo_pop),
    .head_c  (fifo_head),
    .peek_c  (fifo_peek),
    .count   (fifo_count),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

  // Words already buffered plus reads on the bus must leave room for one more.
  assign accept_c    = pix_valid_q && pix_ready;
  assign used_c      = UW'(fifo_count) + UW'(cs_q) + UW'(pend_q);
  assign credit_ok_c = !fifo_full && (used_c < UW'(FIFO_DEPTH));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    pop_rem_d     = pop_rem_q;
    avm_address_d = avm_address_q;
    cs_d          = 1'b0;
    pend_d        = cs_q;
    half_d        = half_q;
    pix_valid_d   = pix_valid_q;
    pix_data_d    = pix_data_q;
    pix_last_d    = pix_last_q;
    done_d        = 1'b0;
    fifo_push     = pend_q;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;

    // Pixel register always mirrors the selected half of the FIFO head.
    if (accept_c && !half_q) begin
      pix_data_d = fifo_head[2*PIX_W-1:PIX_W];
      half_d     = 1'b1;
      pix_last_d = (pop_rem_q == CNT_W'(1));
    end else if (accept_c) begin
      fifo_pop   = 1'b1;
      pop_rem_d  = pop_rem_q - CNT_W'(1);
      half_d     = 1'b0;
      pix_last_d = 1'b0;
      if (fifo_count >= CW'(2)) begin
        pix_data_d  = fifo_peek[PIX_W-1:0];
        pix_valid_d = 1'b1;
      end else if (pend_q) begin
        pix_data_d  = avm_readdata[PIX_W-1:0];
        pix_valid_d = 1'b1;
      end else begin
        pix_valid_d = 1'b0;
      end
    end else if (!pix_valid_q && (!fifo_empty || pend_q)) begin
      pix_data_d  = fifo_empty ? avm_readdata[PIX_W-1:0] : fifo_head[PIX_W-1:0];
      pix_valid_d = 1'b1;
      half_d      = 1'b0;
      pix_last_d  = 1'b0;
    end

    if (accept_c && pix_last_q) begin
      done_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            cs_d          = 1'b1;
            avm_address_d = base_addr;
            addr_d        = base_addr + ADDR_W'(1);
            remaining_d   = word_count - CNT_W'(1);
            pop_rem_d     = word_count;
            state_d       = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (remaining_q == '0) begin
          state_d = ST_DRAIN;
        end else if (credit_ok_c) begin
          cs_d          = 1'b1;
          avm_address_d = addr_q;
          addr_d        = addr_q + ADDR_W'(1);
          remaining_d   = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (accept_c && pix_last_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort drops everything, including data of a read still on the bus.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      cs_d        = 1'b0;
      pend_d      = 1'b0;
      fifo_flush  = 1'b1;
      fifo_push   = 1'b0;
      fifo_pop    = 1'b0;
      pix_valid_d = 1'b0;
      pix_last_d  = 1'b0;
      half_d      = 1'b0;
      done_d      = 1'b0;
      remaining_d = '0;
      pop_rem_d   = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      pop_rem_q     <= '0;
      avm_address_q <= '0;
      cs_q          <= 1'b0;
      pend_q        <= 1'b0;
      half_q        <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_last_q    <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      pop_rem_q     <= pop_rem_d;
      avm_address_q <= avm_address_d;
      cs_q          <= cs_d;
      pend_q        <= pend_d;
      half_q        <= half_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      pix_last_q    <= pix_last_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_address    = avm_address_q;
  assign avm_chipselect = cs_q;
  assign avm_write      = 1'b0;
  assign avm_byteenable = BYTEEN_ALL;
  assign pix_data       = pix_data_q;
  assign pix_valid      = pix_valid_q;
  assign pix_last       = pix_last_q;

endmodule

// File: doc/lt24_pixel_fetch_master.md
Name: lt24_pixel_fetch_master

Overview:
- Avalon-MM read master that drains a pixel line from the 32-bit single-port on-chip memory slave and presents it as a 16-bit RGB565 pixel stream toward the LT24 display writer.
- Matches the slave timing: no read strobe (chipselect with write low is a read), unregistered output, fixed read latency of 1 cycle, no waitrequest.
- A small word FIFO with credit-based read issue absorbs backpressure on the pixel stream.

Parameters:
- ADDR_W, 8, word address width, matching a 256-word memory.
- CNT_W, 9, width of word_count; covers 0..256.
- FIFO_DEPTH, 4, word FIFO entries; must be a power of 2 and at least 2.
- PIX_W, 16, pixel width; each 32-bit word carries two pixels.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, latched on start
- word_count  in  CNT_W  words to fetch, latched on start
- abort  in  1  cancel the transfer in progress
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the last pixel is accepted
- avm_address  out  ADDR_W  word address
- avm_chipselect  out  1  read strobe
- avm_write  out  1  constant 0
- avm_byteenable  out  4  constant 4'hF
- avm_readdata  in  32  read data, valid the cycle after chipselect
- pix_data  out  PIX_W  pixel
- pix_valid  out  1  pixel valid
- pix_ready  in  1  sink accepts the pixel
- pix_last  out  1  marks the final pixel of the transfer

Behaviour:
- Reset values: busy, done, avm_chipselect, pix_valid and pix_last are 0; avm_address, pix_data, FIFO and counters are 0.
- States: IDLE, FETCH, DRAIN.
  - IDLE: on start with word_count != 0, latch addr and remaining, then go to FETCH.
  - start with word_count == 0 stays in IDLE and pulses done the next cycle.
  - start while busy is ignored.
- FETCH: read issue rule.
  - Issue a read when remaining != 0 and fifo_count + inflight < FIFO_DEPTH; inflight is 0 or 1.
  - On issue: avm_chipselect=1, avm_address=addr, then addr increments modulo 2^ADDR_W (255 wraps to 0) and remaining decrements.
  - Go to DRAIN when remaining reaches 0 after the final issue.
- Capture: the cycle after an issue, avm_readdata is written into the FIFO unconditionally. The credit rule guarantees space.
- DRAIN: no reads are issued. When the FIFO is empty, inflight is 0 and the last pixel is accepted, pulse done and return to IDLE.
- Pixel unpacking:
  - The FIFO head word is output as low half [15:0] first, then high half [31:16].
  - A half-select bit toggles on each accepted pixel (pix_valid & pix_ready). The word pops when the high half is accepted.
  - pix_data and pix_valid are registered, and hold stable while pix_valid & !pix_ready.
- pix_last is high with the high half of the final word.
- Latency: start at cycle 0 gives chipselect at cycle 1, FIFO write at cycle 2, and pix_valid at cycle 3.
- Throughput: with pix_ready held high, one pixel per cycle is sustained and pix_valid stays continuous until the end.
- Simultaneous FIFO push and pop in one cycle is legal; the count is unchanged.
- abort (any state except IDLE):
  - Next cycle: IDLE, FIFO flushed, pix_valid=0, inflight cleared.
  - The readdata of a read issued in the abort cycle is discarded.
  - done is not pulsed.
  - abort in IDLE has no effect. abort has priority over start.
- Asynchronous reset mid-transfer forces all reset values immediately.
- The avm_* read path drives a memory whose clock enable is held high by the system; this block has no clken output.

Decomposition:
- Package lt24_fetch_pkg: state enum (IDLE/FETCH/DRAIN), PIX_W, BYTEEN_ALL = 4'hF.
- One sub-module: lt24_word_fifo, a synchronous FIFO, FIFO_DEPTH x 32. It provides count, full and empty, a show-ahead head, and a flush input.

Test Plan:
- Basic transfer: memory words 0x22221111 and 0x44443333, base=0x10, count=2, pix_ready=1 -> pixels 0x1111, 0x2222, 0x3333, 0x4444 on cycles 3-6; pix_last on 0x4444; done one cycle later; reads at addresses 0x10 and 0x11 only.
- Address wrap: base=0xFE, count=4 -> avm_address sequence FE, FF, 00, 01; 8 pixels in order.
- Backpressure: count=16, pix_ready toggles 1-0-0-1 pseudo-randomly -> no pixel lost or duplicated, pix_data stable while stalled, and fifo_count+inflight never exceeds 4. Check with an assertion.
- Zero-length transfer: start with count=0 -> busy stays 0, done pulses once, no chipselect.
- Abort: abort at cycle 5 of a count=8 transfer -> busy low at cycle 6, pix_valid 0, no done. A following start with base=0x40, count=1 yields exactly 2 correct pixels.
- Reset and ignored start: reset_n pulsed low mid-transfer -> all outputs at reset values immediately. start while busy -> latched base/count unchanged.
